// File: rtl/ofdm_rx_byte_packer.sv
// QPSK pair -> byte packer with symbol framing, feeding a show-ahead byte FIFO; 1-cycle push-to-output latency.
// Sink backpressure only fills the FIFO: a full FIFO with no pop drops the byte and sets sticky overflow. Optional counters: OFDM_RX_PACKER_STATS_EN.
module ofdm_rx_byte_packer #(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst,
  input  logic                        sys_init,
  input  logic [1:0]                  rx_rcv_data,
  input  logic                        rx_rcv_data_valid,
  input  logic                        rx_symbol_start,
  output logic [7:0]                  byte_data,
  output logic                        byte_sof,
  output logic                        byte_pad,
  output logic                        byte_valid,
  input  logic                        byte_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow
`ifdef OFDM_RX_PACKER_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]        byte_cnt,
  output logic [CNT_WIDTH-1:0]        drop_cnt
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);

  logic       clr;
  logic [1:0] pair_cnt, pair_cnt_nxt;
  logic [7:0] shreg, shreg_nxt;
  logic       sof_pending, sof_pending_nxt;
  logic       push;
  logic [9:0] push_ent;

  assign clr = sys_rst | sys_init;

  // Unfilled low positions of shreg are always zero, so a partial flush is already zero-padded.
  always_comb begin
    pair_cnt_nxt    = pair_cnt;
    shreg_nxt       = shreg;
    sof_pending_nxt = sof_pending;
    push            = 1'b0;
    push_ent        = '0;
    if (rx_rcv_data_valid) begin
      if (rx_symbol_start && pair_cnt != 2'd0) begin
        push            = 1'b1;
        push_ent        = {shreg, sof_pending, 1'b1};
        shreg_nxt       = {rx_rcv_data, 6'b0};
        pair_cnt_nxt    = 2'd1;
        sof_pending_nxt = 1'b1;
      end else if (pair_cnt == 2'd3) begin
        push            = 1'b1;
        push_ent        = {shreg[7:2], rx_rcv_data, sof_pending, 1'b0};
        shreg_nxt       = '0;
        pair_cnt_nxt    = 2'd0;
        sof_pending_nxt = 1'b0;
      end else begin
        case (pair_cnt)
          2'd0:    shreg_nxt[7:6] = rx_rcv_data;
          2'd1:    shreg_nxt[5:4] = rx_rcv_data;
          default: shreg_nxt[3:2] = rx_rcv_data;
        endcase
        pair_cnt_nxt = pair_cnt + 2'd1;
        if (rx_symbol_start) sof_pending_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (clr) begin
      pair_cnt    <= '0;
      shreg       <= '0;
      sof_pending <= 1'b0;
    end else begin
      pair_cnt    <= pair_cnt_nxt;
      shreg       <= shreg_nxt;
      sof_pending <= sof_pending_nxt;
    end
  end

  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   level;
  logic          pop, full, wr_en, drop;
  logic [9:0]    head;

  assign pop   = (level != '0) && byte_ready;
  assign full  = (level == FULL_LVL);
  assign wr_en = push && !clr && (!full || pop);
  assign drop  = push && !clr && full && !pop;

  always_ff @(posedge sys_clk) begin
    if (wr_en) mem[wr_ptr] <= push_ent;
  end

  always_ff @(posedge sys_clk) begin
    if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      if (wr_en && !pop)      level <= level + (AW+1)'(1);
      else if (!wr_en && pop) level <= level - (AW+1)'(1);
      if (drop) overflow <= 1'b1;
    end
  end

  assign head       = mem[rd_ptr];
  assign byte_valid = (level != '0);
  assign byte_data  = byte_valid ? head[9:2] : 8'd0;
  assign byte_sof   = byte_valid & head[1];
  assign byte_pad   = byte_valid & head[0];
  assign fifo_level = level;

`ifdef OFDM_RX_PACKER_STATS_EN
  always_ff @(posedge sys_clk) begin
    if (clr) begin
      byte_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (wr_en && byte_cnt != '1) byte_cnt <= byte_cnt + CNT_WIDTH'(1);
      if (drop && drop_cnt != '1)  drop_cnt <= drop_cnt + CNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_ofdm_rx_byte_packer.sv
// Bench for ofdm_rx_byte_packer: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_ofdm_rx_byte_packer;
  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int CW    = 16;
  localparam int CMAX  = (1 << CW) - 1;

  logic          sys_clk = 1'b0;
  logic          sys_rst, sys_init;
  logic [1:0]    rx_rcv_data;
  logic          rx_rcv_data_valid, rx_symbol_start;
  logic [7:0]    byte_data;
  logic          byte_sof, byte_pad, byte_valid, byte_ready;
  logic [LW-1:0] fifo_level;
  logic          overflow;
`ifdef OFDM_RX_PACKER_STATS_EN
  logic [CW-1:0] byte_cnt, drop_cnt;
`endif

  always #5 sys_clk = ~sys_clk;

  ofdm_rx_byte_packer #(.FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .sys_init(sys_init),
    .rx_rcv_data(rx_rcv_data), .rx_rcv_data_valid(rx_rcv_data_valid),
    .rx_symbol_start(rx_symbol_start),
    .byte_data(byte_data), .byte_sof(byte_sof), .byte_pad(byte_pad),
    .byte_valid(byte_valid), .byte_ready(byte_ready),
    .fifo_level(fifo_level), .overflow(overflow)
`ifdef OFDM_RX_PACKER_STATS_EN
    , .byte_cnt(byte_cnt), .drop_cnt(drop_cnt)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [9:0] m_q[$];
  logic [1:0] m_pairs[$];
  bit         m_sofp, m_ovf;
  int         m_bcnt, m_dcnt;

  logic [LW+11:0] dut_vec;
  assign dut_vec = {byte_valid, byte_data, byte_sof, byte_pad, fifo_level, overflow};

  function automatic logic [9:0] pack(input logic [1:0] p[$], input bit sof, input bit pad);
    int v = 0;
    foreach (p[i]) v += int'(p[i]) << (6 - 2 * i);
    return {v[7:0], sof, pad};
  endfunction

  function automatic void model_reset();
    m_q.delete();
    m_pairs.delete();
    m_sofp = 0; m_ovf = 0; m_bcnt = 0; m_dcnt = 0;
  endfunction

  function automatic void model_step(input bit v, input logic [1:0] d, input bit s, input bit r);
    bit pop = (m_q.size() > 0) && r;
    bit psh = 0;
    logic [9:0] e = '0;
    if (v) begin
      if (s && m_pairs.size() > 0) begin
        e = pack(m_pairs, m_sofp, 1'b1);
        psh = 1;
        m_pairs.delete();
        m_pairs.push_back(d);
        m_sofp = 1;
      end else begin
        m_pairs.push_back(d);
        if (s) m_sofp = 1;
        if (m_pairs.size() == 4) begin
          e = pack(m_pairs, m_sofp, 1'b0);
          psh = 1;
          m_pairs.delete();
          m_sofp = 0;
        end
      end
    end
    if (pop) void'(m_q.pop_front());
    if (psh) begin
      if (m_q.size() < DEPTH) begin
        m_q.push_back(e);
        if (m_bcnt < CMAX) m_bcnt++;
      end else begin
        m_ovf = 1;
        if (m_dcnt < CMAX) m_dcnt++;
      end
    end
  endfunction

  function automatic logic [LW+11:0] exp_vec();
    logic [9:0] h = (m_q.size() != 0) ? m_q[0] : 10'd0;
    return {m_q.size() != 0, h[9:2], h[1], h[0], LW'(m_q.size()), m_ovf};
  endfunction

  task automatic cyc(input bit v, input logic [1:0] d, input bit s, input bit r);
    rx_rcv_data_valid = v; rx_rcv_data = d; rx_symbol_start = s; byte_ready = r;
    model_step(v, d, s, r);
    @(posedge sys_clk); @(negedge sys_clk);
    rx_rcv_data_valid = 0; rx_rcv_data = 0; rx_symbol_start = 0;
  endtask

  task automatic do_reset();
    sys_rst = 1; sys_init = 0; byte_ready = 0;
    rx_rcv_data_valid = 0; rx_rcv_data = 0; rx_symbol_start = 0;
    @(posedge sys_clk); @(posedge sys_clk); @(negedge sys_clk);
    sys_rst = 0;
    model_reset();
  endtask

  // The pair presented alongside the clear pulse must be discarded.
  task automatic do_init(input logic [1:0] d);
    sys_init = 1; rx_rcv_data_valid = 1; rx_rcv_data = d; rx_symbol_start = 1;
    @(posedge sys_clk); @(negedge sys_clk);
    sys_init = 0; rx_rcv_data_valid = 0; rx_rcv_data = 0; rx_symbol_start = 0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (dut_vec !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h required 0", dut_vec); end
    for (int i = 0; i < 8; i++) cyc(1, 2'(i), i == 0, 0);
    do_reset();
    n_tests++;
    if (dut_vec !== '0) begin n_fail++; $display("FAIL reset_after_traffic: got %h required 0", dut_vec); end
`ifdef OFDM_RX_PACKER_STATS_EN
    n_tests++;
    if ({byte_cnt, drop_cnt} !== '0) begin n_fail++; $display("FAIL reset_stats: got %h/%h required 0/0", byte_cnt, drop_cnt); end
`endif
  endtask

  task automatic test_single_byte();
    do_reset();
    cyc(1, 2'd3, 1, 1); cyc(1, 2'd0, 0, 1); cyc(1, 2'd2, 0, 1);
    n_tests++;
    if (byte_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %b required 0", byte_valid); end
    cyc(1, 2'd1, 0, 1);
    n_tests++;
    if ({byte_valid, byte_data, byte_sof, byte_pad} !== {1'b1, 8'hC9, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL single_byte: got v%b %h sof%b pad%b required v1 c9 sof1 pad0", byte_valid, byte_data, byte_sof, byte_pad);
    end
    cyc(0, 2'd0, 0, 1);
    n_tests++;
    if (dut_vec !== exp_vec() || byte_valid !== 1'b0) begin n_fail++; $display("FAIL single_one_cycle: got %h required %h", dut_vec, exp_vec()); end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, 2'd1, i == 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 2'd2, 0, 0);
    n_tests++;
    if (fifo_level !== LW'(2) || dut_vec !== exp_vec()) begin n_fail++; $display("FAIL bp_level: got %0d required 2", fifo_level); end
    n_tests++;
    if ({byte_data, byte_sof} !== {8'h55, 1'b1}) begin n_fail++; $display("FAIL bp_first: got %h sof%b required 55 sof1", byte_data, byte_sof); end
    cyc(0, 2'd0, 0, 1);
    n_tests++;
    if ({byte_valid, byte_data, byte_sof} !== {1'b1, 8'hAA, 1'b0}) begin n_fail++; $display("FAIL bp_second: got v%b %h sof%b required v1 aa sof0", byte_valid, byte_data, byte_sof); end
    cyc(0, 2'd0, 0, 1);
    n_tests++;
    if (fifo_level !== '0 || byte_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got level %0d required 0", fifo_level); end
  endtask

  task automatic test_partial();
    do_reset();
    cyc(1, 2'd1, 1, 0); cyc(1, 2'd2, 0, 0); cyc(1, 2'd3, 1, 0);
    n_tests++;
    if ({byte_valid, byte_data, byte_sof, byte_pad} !== {1'b1, 8'h60, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL partial_flush: got v%b %h sof%b pad%b required v1 60 sof1 pad1", byte_valid, byte_data, byte_sof, byte_pad);
    end
    for (int i = 0; i < 3; i++) cyc(1, 2'd0, 0, 0);
    n_tests++;
    if (fifo_level !== LW'(2) || dut_vec !== exp_vec()) begin n_fail++; $display("FAIL partial_level: got %h required %h", dut_vec, exp_vec()); end
    cyc(0, 2'd0, 0, 1);
    n_tests++;
    if ({byte_valid, byte_data, byte_sof, byte_pad} !== {1'b1, 8'hC0, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL partial_next: got v%b %h sof%b pad%b required v1 c0 sof1 pad0", byte_valid, byte_data, byte_sof, byte_pad);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] sent[17];
    logic [7:0] t;
    do_reset();
    for (int b = 0; b < 17; b++) begin
      t = 8'($urandom);
      sent[b] = t;
      for (int k = 0; k < 4; k++) cyc(1, t[7-2*k -: 2], b == 0 && k == 0, 0);
    end
    n_tests++;
    if (fifo_level !== LW'(16) || overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_state: got level %0d ovf %b required 16 1", fifo_level, overflow); end
`ifdef OFDM_RX_PACKER_STATS_EN
    n_tests++;
    if (byte_cnt !== CW'(16) || drop_cnt !== CW'(1)) begin n_fail++; $display("FAIL ovf_stats: got %0d/%0d required 16/1", byte_cnt, drop_cnt); end
`endif
    for (int i = 0; i < 16; i++) begin
      n_tests++;
      if (byte_valid !== 1'b1 || byte_data !== sent[i]) begin n_fail++; $display("FAIL ovf_drain%0d: got v%b %h required v1 %h", i, byte_valid, byte_data, sent[i]); end
      cyc(0, 2'd0, 0, 1);
    end
    n_tests++;
    if (byte_valid !== 1'b0 || overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_after: got v%b ovf%b required v0 ovf1", byte_valid, overflow); end
  endtask

  task automatic test_full_pop();
    do_reset();
    for (int i = 0; i < 64; i++) cyc(1, 2'($urandom), i == 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 2'($urandom), 0, 0);
    cyc(1, 2'd3, 0, 1);
    n_tests++;
    if (fifo_level !== LW'(16) || overflow !== 1'b0) begin n_fail++; $display("FAIL fullpop_state: got level %0d ovf %b required 16 0", fifo_level, overflow); end
    for (int i = 0; i < 17; i++) begin
      n_tests++;
      if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL fullpop_drain%0d: got %h required %h", i, dut_vec, exp_vec()); end
      cyc(0, 2'd0, 0, 1);
    end
  endtask

  task automatic test_init();
    do_reset();
    cyc(1, 2'd3, 1, 0); cyc(1, 2'd1, 0, 0);
    do_init(2'd3);
    n_tests++;
    if (dut_vec !== '0) begin n_fail++; $display("FAIL init_clear: got %h required 0", dut_vec); end
    for (int i = 0; i < 4; i++) cyc(1, 2'd2, 0, 0);
    n_tests++;
    if ({byte_valid, byte_data, byte_sof, byte_pad, fifo_level} !== {1'b1, 8'hAA, 1'b0, 1'b0, LW'(1)}) begin
      n_fail++; $display("FAIL init_byte: got v%b %h sof%b pad%b lvl%0d required v1 aa sof0 pad0 lvl1", byte_valid, byte_data, byte_sof, byte_pad, fifo_level);
    end
    cyc(0, 2'd0, 0, 1);
    n_tests++;
    if (byte_valid !== 1'b0 || fifo_level !== '0) begin n_fail++; $display("FAIL init_stale: got v%b lvl%0d required v0 lvl0", byte_valid, fifo_level); end
  endtask

  task automatic test_random();
    int rdy_pct;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rdy_pct = ((c / 400) % 2 == 0) ? 15 : 80;
      if ($urandom_range(0, 399) == 0) do_init(2'($urandom));
      else cyc($urandom_range(0, 99) < 75, 2'($urandom), $urandom_range(0, 99) < 10,
               $urandom_range(0, 99) < rdy_pct);
      n_tests++;
      if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL random_c%0d: got %h required %h", c, dut_vec, exp_vec()); end
`ifdef OFDM_RX_PACKER_STATS_EN
      n_tests++;
      if (byte_cnt !== CW'(m_bcnt) || drop_cnt !== CW'(m_dcnt)) begin
        n_fail++; $display("FAIL random_stats_c%0d: got %0d/%0d required %0d/%0d", c, byte_cnt, drop_cnt, m_bcnt, m_dcnt);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_backpressure();
    test_partial();
    test_overflow();
    test_full_pop();
    test_init();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
